elm_mac_pe: RTL
===============

# elm_mac_pe

Parametrised processing element for the spiral NN engine array, successor to the fixed-function element. It holds a local weight RAM and loads it from the vertical systolic link. It runs a signed multiply-accumulate over a stream of activations arriving on the horizontal link and returns a shifted, saturated result through a valid/ready handshake. Both links are forwarded to the neighbouring element through one register stage, so elements chain without glue logic.

## Interface
- DataWidth, 16, activation/weight/result width (signed two's complement)
- AccWidth, 40, accumulator width; must be ≥ 2*DataWidth + AddrWidth
- Depth, 64, weight RAM entries
- AddrWidth, 6, clog2(Depth)
- Shift, 8, arithmetic right shift applied to the accumulator before saturation
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  element idle, command accepted when cmd_valid & cmd_ready
- cmd_op  in  2  00 LOAD, 01 MAC, 10/11 reserved (accepted, treated as no-op)
- cmd_len  in  AddrWidth+1  element count; values > Depth clamp to Depth
- v_s_i / v_vld_i  in  DataWidth / 1  vertical data in (weights during LOAD)
- v_s_o / v_vld_o  out  DataWidth / 1  v_s_i / v_vld_i registered one cycle, always
- h_s_i / h_vld_i  in  DataWidth / 1  horizontal activations
- h_s_o / h_vld_o  out  DataWidth / 1  h_s_i / h_vld_i registered one cycle, always
- res_o  out  DataWidth  saturated result
- res_valid  out  1  result held
- res_ready  in  1  result consumed when res_valid & res_ready

## Operation
- States: IDLE, LOAD, MAC, FLUSH, DONE. cmd_ready = 1 only in IDLE.
- IDLE: accept a command and latch op and len (clamped). Zero the write/read pointer and the element counter. LOAD goes to LOAD, MAC goes to MAC (acc cleared), reserved goes to IDLE. len = 0: LOAD returns to IDLE; MAC goes directly to DONE with res_o = 0.
- LOAD: each cycle with v_vld_i = 1 writes v_s_i to RAM[ptr], then ptr++ and cnt++. When cnt reaches len, go to IDLE. v_vld_i = 0 stalls with no write.
- MAC: each cycle with h_vld_i = 1 registers h_s_i * RAM[ptr] (signed, 2*DataWidth) into the product register and marks it valid. ptr++ and cnt++. When cnt reaches len, go to FLUSH. h_vld_i = 0 inserts a bubble.
- Accumulate: a valid product register adds sign-extended into acc one cycle later. acc wraps modulo 2^AccWidth with no internal saturation.
- FLUSH: one cycle to drain the final product into acc, then go to DONE.
- DONE: res_o = sat_DataWidth(acc >>> Shift), held stable. res_valid = 1. On res_ready, go to IDLE and clear res_valid.
- Saturation: the result clamps to [-2^(DataWidth-1), 2^(DataWidth-1)-1].
- Pass-through registers update every cycle in every state and are unaffected by the FSM.
- RAM contents are not reset. Reading an address never loaded returns undefined data; the bench must not depend on it.

## Timing
- Reset (rst low, asynchronous): state IDLE, cmd_ready = 1 after release. res_valid = 0, res_o = 0. v_s_o/h_s_o = 0, v_vld_o/h_vld_o = 0. acc, product register, ptr and cnt = 0. Reset asserted mid-LOAD or mid-MAC aborts the command immediately; only RAM writes already completed are kept.
- Pass-through latency: 1 cycle.
- LOAD: a write issued in cycle n is readable by a MAC in cycle n+1.
- MAC latency: the last valid activation in cycle n gives res_valid = 1 in cycle n+3 (product n+1, acc n+2, DONE n+3).
- The h link has no back-pressure. h_vld_i outside MAC is forwarded but ignored.
- cmd_valid asserted while busy is held by the sender and is not accepted until IDLE.

## Test plan
- Reset mid-MAC: pull rst low for 1 cycle during MAC → all outputs 0 within the reset cycle, cmd_ready = 1 after release, and a new MAC computes correctly.
- Load then MAC: Shift = 0. LOAD len 4 with weights 1, 2, 3, 4, then MAC len 4 with activations 5, 6, 7, 8 → res_o = 70, res_valid 3 cycles after the last activation.
- Bubbles and sign: activations -3, gap, 2 against weights 7, -5 (len 2) → res_o = -31. Pass-through outputs follow the inputs with exactly 1 cycle delay, including the gap cycle.
- Saturation: Shift = 0, DataWidth 16. 4 × (32767 * 32767) → res_o = 32767. Negating the weights → res_o = -32768.
- Boundaries: cmd_len = 0 MAC → DONE with res_o = 0 two cycles after accept. cmd_len = Depth+5 → clamped to Depth, ptr wraps cleanly.
- Handshake: hold res_ready low for 10 cycles → res_o stable and cmd_ready = 0. A cmd_valid offered during DONE is not accepted until the cycle after res_ready.

Source files
------------

// File: rtl/elm_mac_pe.sv
// elm_mac_pe: spiral NN array processing element.
// Holds a local weight RAM loaded from the vertical link, runs a signed MAC
// over activations from the horizontal link, and returns a shifted, saturated
// result over a valid/ready handshake. Both links are forwarded one cycle
// later so neighbouring elements chain directly.
module elm_mac_pe #(
    parameter int unsigned DataWidth = 16,
    parameter int unsigned AccWidth  = 40,
    parameter int unsigned Depth     = 64,
    parameter int unsigned AddrWidth = 6,
    parameter int unsigned Shift     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [AddrWidth:0]   cmd_len,
    input  logic [DataWidth-1:0] v_s_i,
    input  logic                 v_vld_i,
    output logic [DataWidth-1:0] v_s_o,
    output logic                 v_vld_o,
    input  logic [DataWidth-1:0] h_s_i,
    input  logic                 h_vld_i,
    output logic [DataWidth-1:0] h_s_o,
    output logic                 h_vld_o,
    output logic [DataWidth-1:0] res_o,
    output logic                 res_valid,
    input  logic                 res_ready
);

    localparam int unsigned LenWidth  = AddrWidth + 1;
    localparam int unsigned ProdWidth = 2 * DataWidth;
    localparam int unsigned HiWidth   = AccWidth - DataWidth + 1;

    localparam logic [1:0] OpLoad = 2'b00;
    localparam logic [1:0] OpMac  = 2'b01;

    localparam logic [DataWidth-1:0] SatMax = {1'b0, {(DataWidth-1){1'b1}}};
    localparam logic [DataWidth-1:0] SatMin = {1'b1, {(DataWidth-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MAC   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic [LenWidth-1:0]         len_q, len_d;
    logic [LenWidth-1:0]         cnt_q, cnt_d;
    logic [AddrWidth-1:0]        ptr_q, ptr_d;
    logic signed [AccWidth-1:0]  acc_q, acc_d;
    logic signed [ProdWidth-1:0] prod_q, prod_d;
    logic                        prod_vld_q, prod_vld_d;
    logic [DataWidth-1:0]        res_q, res_d;
    logic                        res_valid_q, res_valid_d;
    logic                        cmd_ready_q, cmd_ready_d;

    logic [DataWidth-1:0]        v_s_q, h_s_q;
    logic                        v_vld_q, h_vld_q;

    logic [DataWidth-1:0]        mem [Depth];

    logic                        ram_we_c;
    logic [DataWidth-1:0]        rd_data_c;
    logic [LenWidth-1:0]         len_clamp_c;
    logic [LenWidth-1:0]         cnt_inc_c;
    logic [AddrWidth-1:0]        ptr_inc_c;
    logic signed [AccWidth-1:0]  shifted_c;
    logic [HiWidth-1:0]          hi_bits_c;
    logic [DataWidth-1:0]        sat_c;

    // Weight RAM read port; contents are deliberately not reset.
    assign rd_data_c = mem[ptr_q];

    // Command length clamp, pointer wrap at Depth, element counter increment.
    always_comb begin
        len_clamp_c = (cmd_len > LenWidth'(Depth)) ? LenWidth'(Depth) : cmd_len;
        cnt_inc_c   = cnt_q + LenWidth'(1);
        ptr_inc_c   = (ptr_q == AddrWidth'(Depth - 1)) ? '0 : ptr_q + AddrWidth'(1);
    end

    // Arithmetic shift of the accumulator then clamp into the signed result range.
    always_comb begin
        shifted_c = acc_q >>> Shift;
        hi_bits_c = shifted_c[AccWidth-1:DataWidth-1];
        if ((&hi_bits_c) || !(|hi_bits_c)) begin
            sat_c = shifted_c[DataWidth-1:0];
        end else if (shifted_c[AccWidth-1]) begin
            sat_c = SatMin;
        end else begin
            sat_c = SatMax;
        end
    end

    // Next-state, datapath and output computation.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        prod_vld_d  = 1'b0;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        ram_we_c    = 1'b0;

        // A product registered last cycle lands in the accumulator now.
        if (prod_vld_q) begin
            acc_d = acc_q + AccWidth'(prod_q);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    len_d = len_clamp_c;
                    cnt_d = '0;
                    ptr_d = '0;
                    if (cmd_op == OpLoad) begin
                        state_d = (len_clamp_c == '0) ? ST_IDLE : ST_LOAD;
                    end else if (cmd_op == OpMac) begin
                        acc_d   = '0;
                        state_d = (len_clamp_c == '0) ? ST_DONE : ST_MAC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_LOAD: begin
                if (v_vld_i) begin
                    ram_we_c = 1'b1;
                    ptr_d    = ptr_inc_c;
                    cnt_d    = cnt_inc_c;
                    if (cnt_inc_c == len_q) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_MAC: begin
                if (h_vld_i) begin
                    prod_d     = ProdWidth'($signed(h_s_i)) * ProdWidth'($signed(rd_data_c));
                    prod_vld_d = 1'b1;
                    ptr_d      = ptr_inc_c;
                    cnt_d      = cnt_inc_c;
                    if (cnt_inc_c == len_q) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                res_d       = sat_c;
                res_valid_d = 1'b1;
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    // FSM, datapath and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            ptr_q       <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            prod_vld_q  <= 1'b0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            prod_vld_q  <= prod_vld_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    // Weight RAM write port.
    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            mem[ptr_q] <= v_s_i;
        end
    end

    // Link forwarding: one register stage, independent of the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_s_q   <= '0;
            v_vld_q <= 1'b0;
            h_s_q   <= '0;
            h_vld_q <= 1'b0;
        end else begin
            v_s_q   <= v_s_i;
            v_vld_q <= v_vld_i;
            h_s_q   <= h_s_i;
            h_vld_q <= h_vld_i;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign res_o     = res_q;
    assign res_valid = res_valid_q;
    assign v_s_o     = v_s_q;
    assign v_vld_o   = v_vld_q;
    assign h_s_o     = h_s_q;
    assign h_vld_o   = h_vld_q;

endmodule
